// File: rtl/unipolar_rz_stream.sv
`timescale 1ns/1ps

// Generic synchronous FIFO with occupancy count, DEPTH a power of two.
// Latency: a pushed entry is visible at rd_dat one clock after the push edge.
// Backpressure: wr_rdy drops at full and depends only on the registered level.
module rz_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_rdy = (level != FULL);
  assign rd_vld = (level != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally; level tracks occupancy (push+pop keeps it).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
endmodule

// Multi-channel unipolar RZ encoder fed from a word FIFO, lines in bit lockstep.
// Latency: word into empty idle FIFO at edge t -> pop at t+1 -> line high after t+2.
// Backpressure: in_ready = FIFO not full; back-to-back words stream with no idle clocks.
module unipolar_rz_stream #(
  parameter int DATA_WIDTH       = 24,
  parameter int CHANNELS         = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int BIT_CYCLES       = 63,
  parameter int ZERO_HIGH_CYCLES = 20,
  parameter int ONE_HIGH_CYCLES  = 40,
  parameter int RESET_CYCLES     = 3500,
  parameter int MSB_FIRST        = 1,
  parameter int INVERT           = 0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS-1:0]            line,
  output logic                           busy,
  output logic                           underrun,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
  localparam int WW = CHANNELS * DATA_WIDTH;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0]       CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]       ONE_H     = CW'(ONE_HIGH_CYCLES);
  localparam logic [CW-1:0]       ZERO_H    = CW'(ZERO_HIGH_CYCLES);
  localparam logic [GW-1:0]       GAP_INIT  = GW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0]       BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic                IDLE_BIT  = (INVERT != 0);
  localparam logic [CHANNELS-1:0] IDLE_LINE = {CHANNELS{IDLE_BIT}};

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WW-1:0]        word_q, word_d;
  logic                 last_q, last_d;
  logic [CHANNELS-1:0]  line_q, line_d;

  logic                 head_vld;
  logic                 head_pop;
  logic [WW-1:0]        head_data;
  logic                 head_last;
  logic [CHANNELS-1:0]  cur_bit;
  logic [WW-1:0]        word_shift;

  rz_stream_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_vld  (in_valid),
    .wr_rdy  (in_ready),
    .wr_dat  ({in_last, in_data}),
    .rd_vld  (head_vld),
    .rd_rdy  (head_pop),
    .rd_dat  ({head_last, head_data}),
    .level   (fifo_level)
  );

  // Per-channel current bit and the shift that moves to the next bit.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (MSB_FIRST != 0) begin : g_msb
      assign cur_bit[c]                          = word_q[c*DATA_WIDTH + DATA_WIDTH - 1];
      assign word_shift[c*DATA_WIDTH +: DATA_WIDTH] = word_q[c*DATA_WIDTH +: DATA_WIDTH] << 1;
    end else begin : g_lsb
      assign cur_bit[c]                          = word_q[c*DATA_WIDTH];
      assign word_shift[c*DATA_WIDTH +: DATA_WIDTH] = word_q[c*DATA_WIDTH +: DATA_WIDTH] >> 1;
    end
  end

  assign line = line_q;
  assign busy = (state_q != IDLE) || (fifo_level != '0);

  // Next-state, pop, pulse shaping and underrun detection.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    word_d   = word_q;
    last_d   = last_q;
    line_d   = IDLE_LINE;
    head_pop = 1'b0;
    underrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          head_pop = 1'b1;
          word_d   = head_data;
          last_d   = head_last;
          cyc_d    = '0;
          bit_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        for (int c = 0; c < CHANNELS; c++) begin
          line_d[c] = IDLE_BIT ^ (cyc_q < (cur_bit[c] ? ONE_H : ZERO_H));
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (last_q) begin
              // Frame end: latch gap always, queued words wait behind it.
              state_d = GAP;
              gap_d   = GAP_INIT;
            end else if (head_vld) begin
              // Chain straight into the next word with no idle clock.
              head_pop = 1'b1;
              word_d   = head_data;
              last_d   = head_last;
            end else begin
              underrun = 1'b1;
              state_d  = GAP;
              gap_d    = GAP_INIT;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            word_d = word_shift;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: begin
        state_d = GAP;
        gap_d   = GAP_INIT;
      end
    endcase
  end

  // State registers; reset lands in a full latch gap with lines idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GAP;
      cyc_q   <= '0;
      bit_q   <= '0;
      gap_q   <= GAP_INIT;
      word_q  <= '0;
      last_q  <= 1'b0;
      line_q  <= IDLE_LINE;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      last_q  <= last_d;
      line_q  <= line_d;
    end
  end
endmodule

// File: tb/tb_unipolar_rz_stream.sv
`timescale 1ns/1ps

// Directed bench: two encoder instances (normal MSB-first, inverted LSB-first).
module tb_unipolar_rz_stream;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data_a, in_data_b;
  logic       in_last_a, in_last_b, in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic [1:0] line_a, line_b;
  logic       busy_a, busy_b, underrun_a, underrun_b;
  logic [3:0] level_a, level_b;

  int total = 0;
  int bad   = 0;

  logic [1:0] lnr [0:511];
  logic       bsr [0:511];
  logic       unr [0:511];
  int         rs  [0:63];
  int         rl  [0:63];
  int         nr;

  always #5 clock = ~clock;

  unipolar_rz_stream #(
    .DATA_WIDTH(4), .CHANNELS(2), .FIFO_DEPTH(8), .BIT_CYCLES(10),
    .ZERO_HIGH_CYCLES(3), .ONE_HIGH_CYCLES(7), .RESET_CYCLES(20),
    .MSB_FIRST(1), .INVERT(0)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data_a), .in_last(in_last_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .line(line_a), .busy(busy_a),
    .underrun(underrun_a), .fifo_level(level_a)
  );

  unipolar_rz_stream #(
    .DATA_WIDTH(4), .CHANNELS(2), .FIFO_DEPTH(8), .BIT_CYCLES(10),
    .ZERO_HIGH_CYCLES(3), .ONE_HIGH_CYCLES(7), .RESET_CYCLES(20),
    .MSB_FIRST(0), .INVERT(1)
  ) u_dut_inv (
    .clock(clock), .reset_n(reset_n), .in_data(in_data_b), .in_last(in_last_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .line(line_b), .busy(busy_b),
    .underrun(underrun_b), .fifo_level(level_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input bit sel, input logic [7:0] d, input logic l);
    if (sel) begin in_data_b = d; in_last_b = l; in_valid_b = 1'b1; end
    else     begin in_data_a = d; in_last_a = l; in_valid_a = 1'b1; end
    tick();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Sample 0 is taken now; each later sample follows one more clock edge.
  task automatic capture(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      lnr[i] = sel ? line_b     : line_a;
      bsr[i] = sel ? busy_b     : busy_a;
      unr[i] = sel ? underrun_b : underrun_a;
    end
  endtask

  task automatic find_runs(input int ch, input logic act, input int n);
    nr = 0;
    for (int i = 0; i < n; i++) begin
      if (lnr[i][ch] == act) begin
        if ((i == 0 || lnr[i-1][ch] != act) && nr < 64) begin
          rs[nr] = i;
          rl[nr] = 0;
          nr++;
        end
        if (nr > 0) rl[nr-1]++;
      end
    end
  endtask

  function automatic int busy_fall(input int n);
    for (int i = 0; i < n; i++) if (!bsr[i]) return i;
    return -1;
  endfunction

  function automatic int run_sum();
    int s = 0;
    for (int i = 0; i < nr; i++) s += rl[i];
    return s;
  endfunction

  task automatic busy_count(input string tag);
    int n = 0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n, 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, v, uc, uf, hc;
    int exp_a [4];
    int exp_b [4];
    reset_n = 1'b1;
    in_data_a = '0; in_last_a = 1'b0; in_valid_a = 1'b0;
    in_data_b = '0; in_last_b = 1'b0; in_valid_b = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_line", int'(line_a), 0);
    chk("rst_line_inv", int'(line_b), 3);
    chk("rst_level", int'(level_a), 0);
    chk("rst_underrun", int'(underrun_a), 0);
    chk("rst_busy", int'(busy_a), 1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_in_ready", int'(in_ready_a), 1);
    busy_count("rst_gap_len");

    // Single framed word: ch0=1010, ch1=0101.
    push(1'b0, 8'b0101_1010, 1'b1);
    capture(70, 1'b0);
    exp_a = '{7, 3, 7, 3};
    exp_b = '{3, 7, 3, 7};
    find_runs(0, 1'b1, 70);
    chk("t1_ch0_runs", nr, 4);
    chk("t1_latency", rs[0], 2);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_ch0_len%0d", i), rl[i], exp_a[i]);
    find_runs(1, 1'b1, 70);
    chk("t1_ch1_runs", nr, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_ch1_len%0d", i), rl[i], exp_b[i]);
    chk("t1_busy_fall", busy_fall(70), 61);

    // Three chained words, last only on the third.
    push(1'b0, 8'b0011_1100, 1'b0);
    push(1'b0, 8'b0000_1111, 1'b0);
    push(1'b0, 8'b1001_0110, 1'b1);
    chk("t2_level", int'(level_a), 2);
    capture(150, 1'b0);
    find_runs(0, 1'b1, 150);
    chk("t2_ch0_runs", nr, 12);
    chk("t2_ch0_span", rs[11] - rs[0], 110);
    chk("t2_ch0_high", run_sum(), 68);
    find_runs(1, 1'b1, 150);
    chk("t2_ch1_runs", nr, 12);
    chk("t2_ch1_high", run_sum(), 52);
    uc = 0;
    for (int i = 0; i < 150; i++) if (unr[i]) uc++;
    chk("t2_underrun", uc, 0);
    chk("t2_busy_fall", busy_fall(150), 139);

    // Unterminated word drains the FIFO: underrun pulse, then a full gap.
    push(1'b0, 8'b0000_1010, 1'b0);
    capture(70, 1'b0);
    uc = 0;
    uf = -1;
    for (int i = 0; i < 70; i++) if (unr[i]) begin uc++; if (uf < 0) uf = i; end
    chk("t3_underrun_cnt", uc, 1);
    chk("t3_underrun_at", uf, 40);
    chk("t3_busy_fall", busy_fall(70), 61);

    // Fill the FIFO while the encoder sits in its post-reset gap.
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    n = 0;
    in_valid_a = 1'b1;
    in_data_a  = {~4'd1, 4'd1};
    in_last_a  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      automatic bit took = in_ready_a;
      tick();
      if (took) begin
        n++;
        v = n + 1;
        in_data_a = {~v[3:0], v[3:0]};
        in_last_a = (v == 8);
      end
    end
    in_valid_a = 1'b0;
    chk("t4_accepted", n, 8);
    chk("t4_level_full", int'(level_a), 8);
    chk("t4_ready_full", int'(in_ready_a), 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_ready_a && n < 50);
    chk("t4_pop_wait", n, 9);
    chk("t4_level_after_pop", int'(level_a), 7);
    capture(360, 1'b0);
    find_runs(0, 1'b1, 360);
    chk("t4_runs", nr, 32);
    chk("t4_span", rs[31] - rs[0], 310);
    for (int w = 0; w < 8; w++) begin
      v = 0;
      for (int b = 0; b < 4; b++) v = (v << 1) | ((rl[w*4 + b] == 7) ? 1 : 0);
      chk($sformatf("t4_order_w%0d", w), v, w + 1);
    end
    chk("t4_busy_fall", busy_fall(360), 340);

    // Inverted LSB-first instance: ch0=0001, ch1=1000.
    push(1'b1, 8'b1000_0001, 1'b1);
    capture(70, 1'b1);
    chk("t5_idle_pre", int'(lnr[1]), 3);
    chk("t5_idle_post", int'(lnr[69]), 3);
    exp_a = '{7, 3, 3, 3};
    exp_b = '{3, 3, 3, 7};
    find_runs(0, 1'b0, 70);
    chk("t5_ch0_runs", nr, 4);
    chk("t5_latency", rs[0], 2);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_ch0_len%0d", i), rl[i], exp_a[i]);
    find_runs(1, 1'b0, 70);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_ch1_len%0d", i), rl[i], exp_b[i]);

    // Asynchronous reset in the middle of a bit.
    push(1'b0, 8'b0000_1111, 1'b0);
    push(1'b0, 8'b0000_1111, 1'b1);
    tick(); tick(); tick();
    chk("t6_line_pre", int'(line_a), 3);
    chk("t6_level_pre", int'(level_a), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_line_async", int'(line_a), 0);
    chk("t6_line_inv_async", int'(line_b), 3);
    chk("t6_level_async", int'(level_a), 0);
    chk("t6_busy_async", int'(busy_a), 1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    busy_count("t6_gap_len");
    capture(40, 1'b0);
    hc = 0;
    for (int i = 0; i < 40; i++) if (lnr[i] != 2'b00) hc++;
    chk("t6_no_emit", hc, 0);
    chk("t6_level_end", int'(level_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
